// File: rtl/bsg_test_node_client_out_arb.sv
// Round-robin arbiter sharing one FSB ring output channel between num_req_p sources.
// Holds the grant across valid-then-yumi and caps back-to-back packets per source.
module bsg_test_node_client_out_arb #(
  parameter int ring_width_p = 80,
  parameter int num_req_p    = 2,
  parameter int max_burst_p  = 4
) (
  input  logic                              clk_i,
  input  logic                              reset_i,
  input  logic                              en_i,
  input  logic [num_req_p-1:0]              v_i,
  input  logic [num_req_p*ring_width_p-1:0] data_i,
  output logic [num_req_p-1:0]              yumi_o,
  output logic                              v_o,
  output logic [ring_width_p-1:0]           data_o,
  input  logic                              yumi_i,
  output logic [$clog2(num_req_p)-1:0]      grant_id_o
);

  localparam int id_w_lp    = $clog2(num_req_p);
  localparam int burst_w_lp = $clog2(max_burst_p + 1);
  localparam logic [burst_w_lp-1:0] burst_last_lp = burst_w_lp'(max_burst_p - 1);
  localparam logic [id_w_lp-1:0]    id_max_lp     = id_w_lp'(num_req_p - 1);

  typedef enum logic {UNLOCKED = 1'b0, LOCKED = 1'b1} state_e;

  state_e                state_r, state_n;
  logic [id_w_lp-1:0]    lock_id_r, lock_id_n;
  logic [id_w_lp-1:0]    rr_ptr_r, rr_ptr_n;
  logic [burst_w_lp-1:0] burst_cnt_r, burst_cnt_n;
  logic [id_w_lp-1:0]    rr_eff, winner;
  logic [burst_w_lp-1:0] burst_eff;
  logic                  owner_live, found, delivered;

  function automatic logic [id_w_lp-1:0] wrap_inc(input logic [id_w_lp-1:0] id);
    return (id == id_max_lp) ? '0 : id + id_w_lp'(1);
  endfunction

  assign owner_live = (state_r == LOCKED) && v_i[lock_id_r];

  // An owner whose burst continuation has gone away releases in the same cycle,
  // so arbitration already starts from the slot after it.
  always_comb begin
    rr_eff    = rr_ptr_r;
    burst_eff = burst_cnt_r;
    if (state_r == UNLOCKED) begin
      burst_eff = '0;
    end else if (!v_i[lock_id_r]) begin
      rr_eff    = wrap_inc(lock_id_r);
      burst_eff = '0;
    end
  end

  always_comb begin
    found  = 1'b0;
    winner = rr_eff;
    for (int i = 0; i < num_req_p; i++) begin
      int k;
      k = (int'(rr_eff) + i) % num_req_p;
      if (!found && v_i[k]) begin
        found  = 1'b1;
        winner = id_w_lp'(k);
      end
    end
  end

  always_comb begin
    v_o        = 1'b0;
    grant_id_o = '0;
    if (!reset_i) begin
      if (owner_live) begin
        v_o        = 1'b1;
        grant_id_o = lock_id_r;
      end else begin
        v_o        = en_i & found;
        grant_id_o = winner;
      end
    end
  end

  assign data_o    = data_i[int'(grant_id_o)*ring_width_p +: ring_width_p];
  assign delivered = v_o & yumi_i;
  assign yumi_o    = delivered ? (num_req_p'(1) << grant_id_o) : '0;

  always_comb begin
    state_n     = owner_live ? LOCKED : UNLOCKED;
    lock_id_n   = lock_id_r;
    rr_ptr_n    = rr_eff;
    burst_cnt_n = burst_eff;
    if (delivered) begin
      if (burst_eff == burst_last_lp || !en_i) begin
        state_n     = UNLOCKED;
        rr_ptr_n    = wrap_inc(grant_id_o);
        burst_cnt_n = '0;
      end else begin
        state_n     = LOCKED;
        lock_id_n   = grant_id_o;
        burst_cnt_n = burst_eff + burst_w_lp'(1);
      end
    end else if (v_o) begin
      state_n   = LOCKED;
      lock_id_n = grant_id_o;
    end
  end

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      state_r     <= UNLOCKED;
      lock_id_r   <= '0;
      rr_ptr_r    <= '0;
      burst_cnt_r <= '0;
    end else begin
      state_r     <= state_n;
      lock_id_r   <= lock_id_n;
      rr_ptr_r    <= rr_ptr_n;
      burst_cnt_r <= burst_cnt_n;
    end
  end

  // An offered packet must stay on the ring until accepted.
  a_no_retract: assert property (@(posedge clk_i) disable iff (reset_i)
    (v_o && !yumi_i) |=> (v_o && grant_id_o == $past(grant_id_o)));

  a_yumi_with_v: assert property (@(posedge clk_i) disable iff (reset_i)
    yumi_i |-> v_o);

endmodule

// File: tb/tb_bsg_test_node_client_out_arb.sv
// Directed bench for the ring output arbiter: 3 sources, burst limit 2,
// packet scoreboard tracks every accepted packet against the expected source order.
module tb_bsg_test_node_client_out_arb;
  localparam int W  = 16;
  localparam int N  = 3;
  localparam int MB = 2;

  logic clk = 1'b0;
  logic rst, en, yumi_req, yumi_i, v_o;
  logic [N-1:0]   v, yumi_o;
  logic [N*W-1:0] data;
  logic [W-1:0]   data_o;
  logic [1:0]     gid;

  int cnt[N];
  int seq[N];
  int n_assert = 0;
  int n_fail   = 0;
  int seq1_before;
  logic [W-1:0] exp_q[$];
  int order[8] = '{0, 0, 1, 1, 2, 2, 0, 0};

  always #5 clk = ~clk;

  // The ring accepts whatever is offered while yumi_req is high.
  assign yumi_i = yumi_req & v_o;

  bsg_test_node_client_out_arb #(
    .ring_width_p(W), .num_req_p(N), .max_burst_p(MB)
  ) dut (
    .clk_i(clk), .reset_i(rst), .en_i(en), .v_i(v), .data_i(data),
    .yumi_o(yumi_o), .v_o(v_o), .data_o(data_o), .yumi_i(yumi_i),
    .grant_id_o(gid)
  );

  function automatic logic [W-1:0] pkt(input int r, input int s);
    return {r[3:0], s[11:0]};
  endfunction

  task automatic drive();
    for (int r = 0; r < N; r++) begin
      v[r] = (cnt[r] > 0);
      data[r*W +: W] = pkt(r, seq[r]);
    end
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_out(input string tag, input logic ev, input int eg, input logic [N-1:0] ey);
    chk({tag, "_v"}, 32'(v_o), 32'(ev));
    chk({tag, "_yumi"}, 32'(yumi_o), 32'(ey));
    if (ev) begin
      chk({tag, "_gid"}, 32'(gid), 32'(eg));
      chk({tag, "_data"}, 32'(data_o), 32'(pkt(eg, seq[eg])));
    end
  endtask

  task automatic expect_pkt(input int g);
    exp_q.push_back(pkt(g, seq[g]));
  endtask

  // Capture the accepted packet, advance the clock, then let the sources dequeue.
  task automatic tick();
    logic [N-1:0] y;
    logic [W-1:0] d;
    y = yumi_o;
    d = data_o;
    @(posedge clk);
    #1;
    if (|y) begin
      chk("sb_expected", 32'(exp_q.size() != 0), 32'd1);
      if (exp_q.size() != 0) chk("sb_data", 32'(d), 32'(exp_q.pop_front()));
    end
    for (int r = 0; r < N; r++) begin
      if (y[r]) begin
        seq[r]++;
        if (cnt[r] > 0) cnt[r]--;
      end
    end
    drive();
  endtask

  initial begin
    rst = 1'b1; en = 1'b1; yumi_req = 1'b0;
    for (int r = 0; r < N; r++) begin
      cnt[r] = 100;
      seq[r] = 0;
    end
    drive();
    @(posedge clk);
    #1;
    chk("rst_v", 32'(v_o), 32'd0);
    chk("rst_yumi", 32'(yumi_o), 32'd0);
    chk("rst_gid", 32'(gid), 32'd0);
    chk("rst_data", 32'(data_o), 32'(pkt(0, 0)));
    #2 rst = 1'b0;
    #1;
    chk_out("first_grant", 1'b1, 0, '0);
    tick();

    // All sources busy, ring always ready: pairs of packets per source.
    yumi_req = 1'b1;
    for (int i = 0; i < 8; i++) begin
      expect_pkt(order[i]);
      #1;
      chk_out("rr_burst", 1'b1, order[i], N'(1 << order[i]));
      tick();
    end

    // Ring stalls for five cycles while req0 joins; grant must not move.
    yumi_req = 1'b0;
    cnt[0] = 0; cnt[1] = 1; cnt[2] = 0;
    drive();
    #1;
    chk_out("hold", 1'b1, 1, '0);
    tick();
    cnt[0] = 1;
    drive();
    for (int i = 0; i < 4; i++) begin
      #1;
      chk_out("hold", 1'b1, 1, '0);
      tick();
    end
    yumi_req = 1'b1;
    expect_pkt(1);
    #1;
    chk_out("hold_ack", 1'b1, 1, 3'b010);
    tick();

    // req2 sends one packet then goes idle; search restarts at 0 with a fresh burst.
    cnt[2] = 1;
    drive();
    expect_pkt(2);
    #1;
    chk_out("cut_first", 1'b1, 2, 3'b100);
    tick();
    yumi_req = 1'b0;
    cnt[1] = 1;
    drive();
    #1;
    chk_out("cut_next", 1'b1, 0, '0);
    tick();
    cnt[0] = 2;
    yumi_req = 1'b1;
    drive();
    for (int i = 0; i < 2; i++) begin
      expect_pkt(0);
      #1;
      chk_out("cut_burst", 1'b1, 0, 3'b001);
      tick();
    end
    yumi_req = 1'b0;
    cnt[1] = 0;
    drive();
    #1;
    chk_out("idle", 1'b0, 0, '0);
    tick();

    // Disable while req0 holds an unacked packet.
    cnt[0] = 3;
    drive();
    #1;
    chk_out("en_lock", 1'b1, 0, '0);
    tick();
    en = 1'b0;
    #1;
    chk_out("en_hold", 1'b1, 0, '0);
    tick();
    yumi_req = 1'b1;
    expect_pkt(0);
    #1;
    chk_out("en_ack", 1'b1, 0, 3'b001);
    tick();
    cnt[2] = 1;
    drive();
    for (int i = 0; i < 2; i++) begin
      #1;
      chk_out("en_off", 1'b0, 0, '0);
      tick();
    end
    yumi_req = 1'b0;
    en = 1'b1;
    cnt[1] = 1;
    drive();
    #1;
    chk_out("en_resume", 1'b1, 1, '0);
    tick();

    // Async reset pulse mid-cycle while req1 is locked and unacked.
    cnt[0] = 0; cnt[1] = 5; cnt[2] = 0;
    drive();
    seq1_before = seq[1];
    #1;
    chk_out("pre_rst", 1'b1, 1, '0);
    #1 rst = 1'b1;
    yumi_req = 1'b1;
    #1;
    chk_out("in_rst", 1'b0, 0, '0);
    chk("in_rst_gid", 32'(gid), 32'd0);
    rst = 1'b0;
    expect_pkt(1);
    #1;
    chk_out("post_rst", 1'b1, 1, 3'b010);
    tick();
    expect_pkt(1);
    #1;
    chk_out("post_rst_next", 1'b1, 1, 3'b010);
    tick();
    yumi_req = 1'b0;
    #1;
    chk("sb_empty", 32'(exp_q.size()), 32'd0);
    chk("rst_seq1", 32'(seq[1]), 32'(seq1_before + 2));

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end
endmodule
